// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: requests the bus, shifts one command byte
// out with odd parity on device clock edges, and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic       kb_clk_oe,
  output logic       kb_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_W = 19;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic             r_clk_meta;
  logic             r_clk_sync;
  logic             r_clk_prev;
  logic             r_dat_meta;
  logic             r_dat_sync;
  logic             w_fe;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_cnt;
  logic [9:0]       r_shift;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       w_bit_nx;
  logic [9:0]       w_shift_nx;
  logic             w_clk_oe_nx;
  logic             w_data_oe_nx;
  logic             w_busy_nx;
  logic             w_done_nx;
  logic             w_error_nx;
  logic             w_timeout;

  // Pin synchronizers; reset to the idle (high) bus level so no false edge appears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= kb_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= kb_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fe      = r_clk_prev & ~r_clk_sync;
  assign w_timeout = (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 19'd0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 10'd0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_bit_cnt <= w_bit_nx;
      r_shift   <= w_shift_nx;
      r_clk_oe  <= w_clk_oe_nx;
      r_data_oe <= w_data_oe_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_error   <= w_error_nx;
    end
  end

  // Next-state and next-output logic; every abort path funnels into S_ERR.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_bit_nx     = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_clk_oe_nx  = r_clk_oe;
    w_data_oe_nx = r_data_oe;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_error_nx   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nx  = 1'b0;
        w_data_oe_nx = 1'b0;
        w_busy_nx    = 1'b0;
        if (tx_start) begin
          w_state_nx  = S_INHIBIT;
          w_cnt_nx    = 19'd0;
          w_bit_nx    = 4'd0;
          w_shift_nx  = {1'b1, odd_parity(tx_data), tx_data};
          w_clk_oe_nx = 1'b1;
          w_busy_nx   = 1'b1;
        end else begin
          w_cnt_nx = 19'd0;
        end
      end

      S_INHIBIT: begin
        if (r_cnt == INHIBIT_LAST) begin
          w_state_nx   = S_REQ;
          w_data_oe_nx = 1'b1;
          w_cnt_nx     = 19'd0;
        end else begin
          w_cnt_nx = r_cnt + 19'd1;
        end
      end

      S_REQ: begin
        w_state_nx  = S_SEND;
        w_clk_oe_nx = 1'b0;
        w_cnt_nx    = 19'd0;
      end

      // Each device falling edge presents the next bit: data, parity, then stop (released).
      S_SEND: begin
        if (w_fe) begin
          w_cnt_nx     = 19'd0;
          w_data_oe_nx = ~r_shift[0];
          w_shift_nx   = {1'b0, r_shift[9:1]};
          w_bit_nx     = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd9) begin
            w_state_nx = S_ACK;
          end else begin
            w_state_nx = S_SEND;
          end
        end else if (w_timeout) begin
          w_state_nx   = S_ERR;
          w_error_nx   = 1'b1;
          w_busy_nx    = 1'b0;
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_cnt_nx     = 19'd0;
        end else begin
          w_cnt_nx = r_cnt + 19'd1;
        end
      end

      S_ACK: begin
        if (w_fe) begin
          w_cnt_nx = 19'd0;
          if (!r_dat_sync) begin
            w_state_nx = S_WAIT_IDLE;
          end else begin
            w_state_nx   = S_ERR;
            w_error_nx   = 1'b1;
            w_busy_nx    = 1'b0;
            w_clk_oe_nx  = 1'b0;
            w_data_oe_nx = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_nx   = S_ERR;
          w_error_nx   = 1'b1;
          w_busy_nx    = 1'b0;
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_cnt_nx     = 19'd0;
        end else begin
          w_cnt_nx = r_cnt + 19'd1;
        end
      end

      S_WAIT_IDLE: begin
        if (r_clk_sync && r_dat_sync) begin
          w_state_nx   = S_DONE;
          w_done_nx    = 1'b1;
          w_busy_nx    = 1'b0;
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_cnt_nx     = 19'd0;
        end else if (w_fe) begin
          w_cnt_nx = 19'd0;
        end else if (w_timeout) begin
          w_state_nx   = S_ERR;
          w_error_nx   = 1'b1;
          w_busy_nx    = 1'b0;
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_cnt_nx     = 19'd0;
        end else begin
          w_cnt_nx = r_cnt + 19'd1;
        end
      end

      S_DONE: begin
        w_state_nx = S_IDLE;
      end

      S_ERR: begin
        w_state_nx   = S_IDLE;
        w_clk_oe_nx  = 1'b0;
        w_data_oe_nx = 1'b0;
      end

      default: begin
        w_state_nx   = S_IDLE;
        w_clk_oe_nx  = 1'b0;
        w_data_oe_nx = 1'b0;
        w_busy_nx    = 1'b0;
        w_cnt_nx     = 19'd0;
      end
    endcase
  end

  assign kb_clk_oe  = r_clk_oe;
  assign kb_data_oe = r_data_oe;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_error   = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks each transfer;
// a monitor scores sampled line bits, done/error pulses and queued direct checks.
module tb_ps2_host_tx;

  localparam int INHIBIT = 3000;
  localparam int TIMEOUT = 4000;
  localparam int HALF    = 750;
  localparam logic [1:0] K_BIT  = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       kb_clk;
  logic       kb_data;
  logic       kb_clk_oe;
  logic       kb_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  logic       smp_stb = 1'b0;
  logic       smp_val = 1'b0;

  logic [2:0] ev_q[$];
  string      nm_q[$];
  int         act_q[$];
  int         req_q[$];

  int n_vec = 0;
  int n_err = 0;

  assign kb_clk  = dev_clk  & ~kb_clk_oe;
  assign kb_data = dev_data & ~kb_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .kb_clk    (kb_clk),
    .kb_data   (kb_data),
    .kb_clk_oe (kb_clk_oe),
    .kb_data_oe(kb_data_oe),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #20 clk = ~clk;

  task automatic score(input logic [2:0] obs);
    logic [2:0] e;
    n_vec++;
    if (ev_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: unexpected event kind/val=%0h with empty queue", obs);
    end else begin
      e = ev_q.pop_front();
      if (e !== obs) begin
        n_err++;
        $display("FAIL scoreboard: event kind/val got %0h expected %0h", obs, e);
      end
    end
  endtask

  // Monitor: scores every DUT-visible event and every queued direct check.
  always @(negedge clk) begin
    if (smp_stb)  score({K_BIT, smp_val});
    if (tx_done)  score({K_DONE, 1'b0});
    if (tx_error) score({K_ERR, 1'b0});
    while (nm_q.size() > 0) begin
      string nm;
      int    a;
      int    r;
      nm = nm_q.pop_front();
      a  = act_q.pop_front();
      r  = req_q.pop_front();
      n_vec++;
      if (a != r) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d", nm, a, r);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string nm, input int act, input int req);
    nm_q.push_back(nm);
    act_q.push_back(act);
    req_q.push_back(req);
  endtask

  // Queue the start bit and the first n line levels of {stop, parity, data}.
  task automatic push_bits(input logic [9:0] bits, input int n);
    ev_q.push_back({K_BIT, 1'b0});
    for (int i = 0; i < n; i++) ev_q.push_back({K_BIT, bits[i]});
  endtask

  task automatic start_tx(input logic [7:0] b, input bit poke);
    int hi;
    tx_data  = b;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    expect_eq("busy_after_accept", int'(tx_busy), 1);
    expect_eq("clk_oe_after_accept", int'(kb_clk_oe), 1);
    expect_eq("data_oe_in_inhibit", int'(kb_data_oe), 0);
    hi = 1;
    while (kb_clk_oe && hi < 10000) begin
      if (poke && hi == 100) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      cyc(1);
      if (kb_clk_oe) hi++;
    end
    tx_start = 1'b0;
    expect_eq("clk_oe_window", hi, INHIBIT + 1);
    expect_eq("start_bit_data_oe", int'(kb_data_oe), 1);
  endtask

  // Device model: samples the start bit, then generates nfe clock pulses.
  task automatic dev_run(input int nfe, input bit ack);
    smp_val = kb_data;
    smp_stb = 1'b1;
    cyc(1);
    smp_stb = 1'b0;
    cyc(HALF);
    for (int i = 1; i <= nfe; i++) begin
      dev_clk = 1'b0;
      cyc(HALF);
      if (i <= 10) begin
        smp_val = kb_data;
        smp_stb = 1'b1;
      end
      dev_clk = 1'b1;
      cyc(1);
      smp_stb = 1'b0;
      cyc(HALF - 1);
      if (i == 10) dev_data = ack ? 1'b0 : 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic finish_tx(input string nm);
    int n;
    n = 0;
    while (tx_busy && n < 200) begin
      cyc(1);
      n++;
    end
    expect_eq({nm, "_busy_low"}, int'(tx_busy), 0);
    expect_eq({nm, "_clk_oe_low"}, int'(kb_clk_oe), 0);
    expect_eq({nm, "_data_oe_low"}, int'(kb_data_oe), 0);
    cyc(5);
  endtask

  initial begin
    int c;
    reset = 1'b0;
    cyc(3);
    expect_eq("rst_clk_oe", int'(kb_clk_oe), 0);
    expect_eq("rst_data_oe", int'(kb_data_oe), 0);
    expect_eq("rst_busy", int'(tx_busy), 0);
    expect_eq("rst_done", int'(tx_done), 0);
    expect_eq("rst_error", int'(tx_error), 0);
    reset = 1'b1;
    cyc(5);

    // 0xED with ACK; a tx_start of 0x00 during INHIBIT must be ignored.
    push_bits(10'h3ED, 10);
    ev_q.push_back({K_DONE, 1'b0});
    start_tx(8'hED, 1'b1);
    dev_run(11, 1'b1);
    finish_tx("ed");

    // 0xF4 (parity 0), device withholds the ACK.
    push_bits(10'h2F4, 10);
    ev_q.push_back({K_ERR, 1'b0});
    start_tx(8'hF4, 1'b0);
    dev_run(11, 1'b0);
    finish_tx("f4_noack");

    // Device never clocks: error exactly TIMEOUT cycles after clk_oe release.
    ev_q.push_back({K_BIT, 1'b0});
    ev_q.push_back({K_ERR, 1'b0});
    start_tx(8'hAA, 1'b0);
    smp_val = kb_data;
    smp_stb = 1'b1;
    c = 0;
    while (!tx_error && c < TIMEOUT + 100) begin
      cyc(1);
      smp_stb = 1'b0;
      c++;
    end
    smp_stb = 1'b0;
    expect_eq("timeout_cycles", c, TIMEOUT);
    expect_eq("timeout_clk_oe", int'(kb_clk_oe), 0);
    expect_eq("timeout_data_oe", int'(kb_data_oe), 0);
    finish_tx("timeout");

    // Reset after fe 4 of 0x55, then a clean 0xFF transfer.
    push_bits(10'h355, 4);
    start_tx(8'h55, 1'b0);
    dev_run(4, 1'b0);
    expect_eq("pre_reset_data_oe", int'(kb_data_oe), 1);
    reset = 1'b0;
    cyc(1);
    expect_eq("mid_rst_clk_oe", int'(kb_clk_oe), 0);
    expect_eq("mid_rst_data_oe", int'(kb_data_oe), 0);
    expect_eq("mid_rst_busy", int'(tx_busy), 0);
    expect_eq("mid_rst_done", int'(tx_done), 0);
    expect_eq("mid_rst_error", int'(tx_error), 0);
    reset = 1'b1;
    cyc(10);

    push_bits(10'h3FF, 10);
    ev_q.push_back({K_DONE, 1'b0});
    start_tx(8'hFF, 1'b0);
    dev_run(11, 1'b1);
    finish_tx("ff");

    cyc(10);
    expect_eq("scoreboard_drained", ev_q.size(), 0);
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(40 * 150000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
